// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO controller that sequences the team's dual-port RAM.
package fifo_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 8;

  // Sticky error flags; cleared only by reset.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer: advances by one on en_i, wrapping from DEPTH-1 to 0.
module fifo_ptr #(
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W,
  parameter int unsigned DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Explicit wrap so DEPTH need not be a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy and flags for an external dual-port RAM with
// one-cycle read latency. Holds no storage of its own.
module fifo_ctrl #(
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W,
  parameter int unsigned DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  import fifo_pkg::*;

  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_d;
  logic            rd_valid_q;
  logic            rd_valid_d;
  err_flags_t      err_q;
  err_flags_t      err_d;

  // Flags come from registered occupancy only; enables gate the raw requests.
  assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign write_en = push & ~full;
  assign read_en  = pop & ~empty;

  fifo_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (write_en),
    .ptr_o (write_addr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (read_en),
    .ptr_o (read_addr)
  );

  always_comb begin
    count_d    = count_q;
    rd_valid_d = read_en;
    err_d      = err_q;
    unique case ({write_en, read_en})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push & full) begin
      err_d.overflow = 1'b1;
    end
    if (pop & empty) begin
      err_d.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: behavioural RAM plus a queue-based FIFO reference model.
module tb_fifo_ctrl;

  import fifo_pkg::*;

  localparam int unsigned AW = ADDR_W;
  localparam int unsigned DW = DATA_W;
  localparam int          DI = int'(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n, push, pop;
  logic          write_en, read_en, rd_valid, full, empty, overflow, underflow;
  logic [AW-1:0] write_addr, read_addr;
  logic [AW:0]   count;
  logic [DW-1:0] din, d_out;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .write_en   (write_en),
    .write_addr (write_addr),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Dual-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (write_en) mem[write_addr] <= din;
    if (read_en)  d_out <= mem[read_addr];
  end

  logic [DW-1:0] q[$];
  int            wp, rp;
  bit            ovf, unf, exp_rdv;
  logic [DW-1:0] exp_dout;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic apply(input bit p, input bit r, input logic [DW-1:0] d);
    push = p; pop = r; din = d;
    @(negedge clk);
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit aw, ar;
    if (!rst_n) begin
      q.delete(); wp = 0; rp = 0; ovf = 0; unf = 0; exp_rdv = 0;
    end else begin
      aw = push && (q.size() < DI);
      ar = pop && (q.size() > 0);
      if (push && q.size() == DI) ovf = 1;
      if (pop && q.size() == 0) unf = 1;
      exp_rdv = ar;
      if (ar) begin exp_dout = q.pop_front(); rp = (rp + 1) % DI; end
      if (aw) begin q.push_back(din); wp = (wp + 1) % DI; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(0, 0, '0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (write_addr !== '0 || read_addr !== '0) begin
      n_fail++; $display("FAIL reset_ptrs: got wa=%0d ra=%0d want 0/0", write_addr, read_addr);
    end
    n_checks++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: got rdv=%b ovf=%b unf=%b want 0", rd_valid, overflow, underflow);
    end
    n_checks++; if (write_en !== 1'b0 || read_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_enables: got we=%b re=%b want 0/0", write_en, read_en);
    end
  endtask

  task automatic test_push3();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, DW'(i));
      n_checks++; if (write_en !== 1'b1 || write_addr !== AW'(i)) begin
        n_fail++; $display("FAIL push3_write: got we=%b wa=%0d want 1/%0d", write_en, write_addr, i);
      end
      tick();
    end
    apply(0, 0, '0);
    n_checks++; if (count !== (AW+1)'(3) || empty !== 1'b0) begin
      n_fail++; $display("FAIL push3_count: got count=%0d empty=%b want 3/0", count, empty);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(0, 1, '0);
    n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL uf_read_en: got %b want 0", read_en); end
    tick();
    apply(0, 0, '0);
    n_checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL uf_flag: got unf=%b rdv=%b want 1/0", underflow, rd_valid);
    end
    n_checks++; if (read_addr !== '0 || write_addr !== '0 || count !== '0) begin
      n_fail++; $display("FAIL uf_state: got ra=%0d wa=%0d cnt=%0d want 0/0/0", read_addr, write_addr, count);
    end
  endtask

  task automatic test_data();
    do_reset();
    apply(1, 0, 8'hA5);
    n_checks++; if (write_addr !== '0 || write_en !== 1'b1) begin
      n_fail++; $display("FAIL data_write: got wa=%0d we=%b want 0/1", write_addr, write_en);
    end
    tick();
    apply(0, 1, '0);
    n_checks++; if (read_en !== 1'b1 || read_addr !== '0) begin
      n_fail++; $display("FAIL data_read: got re=%b ra=%0d want 1/0", read_en, read_addr);
    end
    tick();
    n_checks++; if (rd_valid !== 1'b1 || d_out !== 8'hA5) begin
      n_fail++; $display("FAIL data_out: got rdv=%b d=%h want 1/a5", rd_valid, d_out);
    end
    apply(0, 0, '0);
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL data_rdv_drop: got %b want 0", rd_valid); end
  endtask

  task automatic test_both_empty();
    do_reset();
    apply(1, 1, 8'h3C);
    n_checks++; if (write_en !== 1'b1 || read_en !== 1'b0) begin
      n_fail++; $display("FAIL both_empty_en: got we=%b re=%b want 1/0", write_en, read_en);
    end
    tick();
    n_checks++; if (count !== (AW+1)'(1) || underflow !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL both_empty_state: got cnt=%0d unf=%b rdv=%b want 1/1/0", count, underflow, rd_valid);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    do_reset();
    for (int i = 0; i < DI; i++) begin
      apply(1, 0, DW'($urandom));
      if (write_en !== 1'b1) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fill_write_en: got %0d rejected want 0", bad); end
    apply(1, 0, 8'hFF);
    n_checks++; if (full !== 1'b1 || count !== (AW+1)'(DEPTH) || write_en !== 1'b0) begin
      n_fail++; $display("FAIL full_state: got full=%b cnt=%0d we=%b want 1/%0d/0", full, count, write_en, DEPTH);
    end
    tick();
    n_checks++; if (overflow !== 1'b1 || count !== (AW+1)'(DEPTH) || underflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow: got ovf=%b cnt=%0d unf=%b want 1/%0d/0", overflow, count, underflow, DEPTH);
    end
    apply(1, 1, 8'h77);
    n_checks++; if (write_en !== 1'b0 || read_en !== 1'b1) begin
      n_fail++; $display("FAIL both_full_en: got we=%b re=%b want 0/1", write_en, read_en);
    end
    tick();
    n_checks++; if (count !== (AW+1)'(DEPTH - 1) || read_addr !== AW'(1) || write_addr !== '0) begin
      n_fail++; $display("FAIL both_full_state: got cnt=%0d ra=%0d wa=%0d want %0d/1/0", count, read_addr, write_addr, DEPTH - 1);
    end
    n_checks++; if (rd_valid !== 1'b1 || d_out !== exp_dout) begin
      n_fail++; $display("FAIL both_full_data: got rdv=%b d=%h want 1/%h", rd_valid, d_out, exp_dout);
    end
  endtask

  // One randomized cycle checked against the queue model.
  task automatic rand_cycle(input bit p, input bit r);
    apply(p, r, DW'($urandom));
    n_checks++; if (write_en !== (p && q.size() < DI) || read_en !== (r && q.size() > 0)) begin
      n_fail++; $display("FAIL rnd_enables: got we=%b re=%b occ=%0d p=%b r=%b", write_en, read_en, q.size(), p, r);
    end
    n_checks++; if (write_addr !== AW'(wp) || read_addr !== AW'(rp)) begin
      n_fail++; $display("FAIL rnd_ptrs: got wa=%0d ra=%0d want %0d/%0d", write_addr, read_addr, wp, rp);
    end
    tick();
    n_checks++; if (count !== (AW+1)'(q.size()) || full !== (q.size() == DI) || empty !== (q.size() == 0)) begin
      n_fail++; $display("FAIL rnd_occ: got cnt=%0d f=%b e=%b want %0d", count, full, empty, q.size());
    end
    n_checks++; if (rd_valid !== exp_rdv || overflow !== ovf || underflow !== unf) begin
      n_fail++; $display("FAIL rnd_flags: got rdv=%b ovf=%b unf=%b want %b/%b/%b", rd_valid, overflow, underflow, exp_rdv, ovf, unf);
    end
    if (exp_rdv) begin
      n_checks++; if (d_out !== exp_dout) begin n_fail++; $display("FAIL rnd_data: got %h want %h", d_out, exp_dout); end
    end
  endtask

  task automatic test_wrap_stream();
    do_reset();
    for (int i = 0; i < 10; i++) rand_cycle(1, 0);
    for (int i = 0; i < 300; i++) begin
      rand_cycle(1, 0);
      rand_cycle(0, 1);
    end
    n_checks++; if (write_addr !== AW'(310 % DI) || read_addr !== AW'(300 % DI)) begin
      n_fail++; $display("FAIL wrap_ptrs: got wa=%0d ra=%0d want %0d/%0d", write_addr, read_addr, 310 % DI, 300 % DI);
    end
    for (int i = 0; i < 500; i++) rand_cycle(1'($urandom), 1'($urandom));
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 5; i++) rand_cycle(1, 0);
    apply(1, 1, 8'h11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (rd_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got rdv=%b cnt=%0d e=%b want 0/0/1", rd_valid, count, empty);
    end
    n_checks++; if (write_addr !== '0 || read_addr !== '0) begin
      n_fail++; $display("FAIL mid_reset_ptrs: got wa=%0d ra=%0d want 0/0", write_addr, read_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    test_reset();
    test_push3();
    test_underflow();
    test_data();
    test_both_empty();
    test_full();
    test_wrap_stream();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, the RAM address width.
REQ-002 The block SHALL have parameter DEPTH, default 2**ADDR_W (256), the number of RAM entries.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port push, input, 1 bit: the producer requests a write this cycle.
REQ-006 The block SHALL have port pop, input, 1 bit: the consumer requests a read this cycle.
REQ-007 The block SHALL have port write_en, output, 1 bit: drives the RAM write-port enable.
REQ-008 The block SHALL have port write_addr, output, ADDR_W bits: drives the RAM write address.
REQ-009 The block SHALL have port read_en, output, 1 bit: drives the RAM read-port enable.
REQ-010 The block SHALL have port read_addr, output, ADDR_W bits: drives the RAM read address.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: RAM d_out holds popped data this cycle.
REQ-012 The block SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-013 The block SHALL have port count, output, ADDR_W+1 bits: current occupancy, range 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-015 write_en SHALL equal push & ~full, combinationally, in the same cycle as push.
REQ-016 read_en SHALL equal pop & ~empty, combinationally, in the same cycle as pop.
REQ-017 write_addr and read_addr SHALL be the registered write pointer and read pointer respectively.
REQ-018 On each accepted write, the write pointer SHALL increment by 1 at the clock edge, wrapping from DEPTH-1 to 0.
REQ-019 On each accepted read, the read pointer SHALL increment by 1 at the clock edge, wrapping from DEPTH-1 to 0.
REQ-020 count SHALL be updated at the clock edge as follows: +1 on a write only, -1 on a read only, unchanged on both or neither.
REQ-021 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both derived from registered state.
REQ-022 rd_valid SHALL be read_en delayed by exactly one clock cycle, aligned with the RAM's one-cycle read latency.
REQ-023 When full with push and pop both asserted, the pop SHALL be accepted, the push rejected, and count SHALL become DEPTH-1.
REQ-024 When empty with push and pop both asserted, the push SHALL be accepted, the pop rejected, and count SHALL become 1.
REQ-025 When neither full nor empty with push and pop both asserted, both SHALL be accepted, both pointers SHALL advance, and count SHALL be unchanged.
REQ-026 overflow SHALL set at the edge following any cycle with push & full, and SHALL hold until reset.
REQ-027 underflow SHALL set at the edge following any cycle with pop & empty, and SHALL hold until reset.
REQ-028 The block SHALL never assert read_en and write_en to the same address while empty, which follows from REQ-016.

Reset
REQ-029 While rst_n is low at a rising clk edge, the following registers SHALL be cleared to 0: both pointers, count, rd_valid, overflow and underflow.
REQ-030 After reset, outputs SHALL be: empty=1, full=0, write_addr=0, read_addr=0; write_en and read_en low unless push is asserted.
REQ-031 A reset asserted mid-stream SHALL discard all occupancy, with RAM contents left undefined, and SHALL suppress rd_valid in the following cycle.

Structure
REQ-032 ADDR_W, DEPTH and the 8-bit data width constant SHALL live in the shared package fifo_pkg.
REQ-033 A single sub-module fifo_ptr SHALL implement the wrapping pointer with enable, instantiated twice, once for write and once for read.
REQ-034 The block SHALL contain no memory array and SHALL connect port-for-port to the team's dual-port RAM.

Verification
REQ-035 Scenario: reset, then push 3 cycles -> write_addr 0,1,2, count=3, empty=0.
REQ-036 Scenario: push 256 with no pop -> full=1 and count=256; a 257th push gives write_en=0 and overflow=1 next cycle.
REQ-037 Scenario: push data 0xA5 at address 0, then pop -> read_en at read_addr 0, rd_valid=1 one cycle later, d_out=0xA5.
REQ-038 Scenario: pop while empty -> read_en=0, rd_valid=0, underflow=1 next cycle, pointers unchanged.
REQ-039 Scenario: fill to 256, then push and pop together -> count=255, read_addr=1, write_addr=0.
REQ-040 Scenario: 300 pushes interleaved with 300 pops at occupancy 10 -> pointers wrap past 255 to 0, and data order is preserved.
